// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing the MMIO switch/LED port between two bus masters.
// Optional address range checking is enabled by defining MMIO_ARB_RANGE_CHECK_EN.
module mmio_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_rdata_o,
    output logic [31:0] io_addr_o,
    output logic        io_we_o,
    output logic [31:0] io_wdata_o,
    input  logic [31:0] io_rdata_i,
`ifdef MMIO_ARB_RANGE_CHECK_EN
    output logic        m0_err_o,
    output logic        m1_err_o,
`endif
    output logic        busy_o,
    output logic        owner_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [31:0] addr_nxt, wdata_nxt;
    logic        we_nxt, owner_nxt;
    logic        ack0_nxt, ack1_nxt;
    logic [31:0] rdata0_nxt, rdata1_nxt;
    logic        sel;
    logic [31:0] g_addr, g_wdata;
    logic        g_we;
`ifdef MMIO_ARB_RANGE_CHECK_EN
    logic        err0_nxt, err1_nxt;
`endif

    // All io_* and master-facing outputs are registered; this block only
    // computes their next values so every output changes on a clock edge.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        addr_nxt   = io_addr_o;
        we_nxt     = io_we_o;
        wdata_nxt  = io_wdata_o;
        owner_nxt  = owner_o;
        ack0_nxt   = 1'b0;
        ack1_nxt   = 1'b0;
        rdata0_nxt = m0_rdata_o;
        rdata1_nxt = m1_rdata_o;
`ifdef MMIO_ARB_RANGE_CHECK_EN
        err0_nxt   = 1'b0;
        err1_nxt   = 1'b0;
`endif
        sel     = (m0_req_i && m1_req_i) ? ~owner_o : m1_req_i;
        g_addr  = sel ? m1_addr_i  : m0_addr_i;
        g_we    = sel ? m1_we_i    : m0_we_i;
        g_wdata = sel ? m1_wdata_i : m0_wdata_i;

        case (state)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    owner_nxt = sel;
`ifdef MMIO_ARB_RANGE_CHECK_EN
                    if (g_addr[31:8] != 24'hFFFFF0) begin
                        // Out-of-window access never touches the IO bus.
                        state_nxt = RESP;
                        if (sel) begin
                            ack1_nxt   = 1'b1;
                            err1_nxt   = 1'b1;
                            rdata1_nxt = '0;
                        end else begin
                            ack0_nxt   = 1'b1;
                            err0_nxt   = 1'b1;
                            rdata0_nxt = '0;
                        end
                    end else
`endif
                    begin
                        addr_nxt  = g_addr;
                        we_nxt    = g_we;
                        wdata_nxt = g_wdata;
                        cnt_nxt   = 2'(WAIT_CYCLES - 1);
                        state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt == 2'd0) begin
                    state_nxt = RESP;
                    we_nxt    = 1'b0;
                    addr_nxt  = IDLE_ADDR;
                    if (owner_o) begin
                        ack1_nxt   = 1'b1;
                        rdata1_nxt = io_rdata_i;
                    end else begin
                        ack0_nxt   = 1'b1;
                        rdata0_nxt = io_rdata_i;
                    end
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            io_addr_o  <= IDLE_ADDR;
            io_we_o    <= 1'b0;
            io_wdata_o <= '0;
            m0_ack_o   <= 1'b0;
            m1_ack_o   <= 1'b0;
            m0_rdata_o <= '0;
            m1_rdata_o <= '0;
            owner_o    <= 1'b1;
`ifdef MMIO_ARB_RANGE_CHECK_EN
            m0_err_o   <= 1'b0;
            m1_err_o   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            io_addr_o  <= addr_nxt;
            io_we_o    <= we_nxt;
            io_wdata_o <= wdata_nxt;
            m0_ack_o   <= ack0_nxt;
            m1_ack_o   <= ack1_nxt;
            m0_rdata_o <= rdata0_nxt;
            m1_rdata_o <= rdata1_nxt;
            owner_o    <= owner_nxt;
`ifdef MMIO_ARB_RANGE_CHECK_EN
            m0_err_o   <= err0_nxt;
            m1_err_o   <= err1_nxt;
`endif
        end
    end

    assign busy_o = (state != IDLE);

endmodule
